alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 alu_a  input  WIDTH  operand A, two's complement.
REQ-007 alu_b  input  WIDTH  operand B, two's complement.
REQ-008 alu_op  input  5  opcode.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 alu_out  output  WIDTH  result.
REQ-012 zero  output  1  alu_out == 0.
REQ-013 carry  output  1  ADD carry-out / SUB borrow.
REQ-014 overflow  output  1  signed overflow, ADD/SUB only.

Function
REQ-015 Opcodes SHALL be: 00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 NOR, 07 SLT (signed, result 1/0), 08 SLTU (unsigned), 09 SLL, 0A SRL, 0B SRA, 0C MUL (low WIDTH bits of product); all others and NOP yield alu_out 0.
REQ-016 Shift amount SHALL be alu_b[log2(WIDTH)-1:0]; upper bits ignored.
REQ-017 Accept SHALL occur on a rising edge with in_valid && in_ready; operands and opcode are captured at accept.
REQ-018 in_ready SHALL be 1 only in state IDLE and when (!out_valid || out_ready).
REQ-019 FSM states: IDLE, MUL; IDLE->MUL on accept of MUL (when compiled in); MUL->IDLE after WIDTH iteration cycles; all other ops stay IDLE.
REQ-020 Non-MUL ops SHALL have latency 1: accepted at edge k, out_valid=1 with result after edge k.
REQ-021 MUL SHALL be shift-add, one multiplier bit per cycle: accepted at edge k, out_valid=1 after edge k+WIDTH; in_ready=0 throughout.
REQ-022 out_valid, alu_out and flags SHALL hold stable while out_valid && !out_ready.
REQ-023 out_valid SHALL clear on the edge where out_ready=1 unless a new result is written on that same edge (back-to-back: accept and drain on one edge keeps out_valid=1 with new data).
REQ-024 zero SHALL equal (alu_out==0) for every op; carry and overflow SHALL be 0 for ops other than ADD/SUB.
REQ-025 SUB carry SHALL be 1 when alu_a < alu_b unsigned; overflow SHALL follow two's-complement sign rule for ADD and SUB.
REQ-026 in_valid while in_ready=0 SHALL be ignored; the source holds it.

Reset
REQ-027 While rst_n=0 at an edge: state IDLE, out_valid 0, alu_out 0, zero 0, carry 0, overflow 0, multiplier iteration count 0.
REQ-028 Reset during MUL SHALL abort it with no result ever presented.
REQ-029 in_ready SHALL be 1 from the first edge after rst_n returns high.

Configuration
REQ-030 Macro ALU_MUL_EN: when defined, MUL (0C) and state MUL are implemented per REQ-021.
REQ-031 Without ALU_MUL_EN, 0C SHALL behave as an unknown opcode: latency 1, alu_out 0, zero 1, FSM never leaves IDLE.

Structure
REQ-032 Package alu_pkg SHALL hold opcode constants (A_NOP..A_MUL) and the FSM state typedef.
REQ-033 Iterative multiplier SHALL be sub-module alu_mul_iter (start, a, b -> done, product), instantiated only under ALU_MUL_EN.
REQ-034 Target size 120-400 lines RTL total.

Verification (WIDTH=32)
REQ-035 ADD 0x7FFFFFFF+1 -> alu_out 0x80000000, overflow 1, carry 0, zero 0, out_valid one cycle after accept.
REQ-036 SUB 0x5-0x5 -> 0, zero 1, carry 0; SUB 0x0-0x1 -> 0xFFFFFFFF, carry 1; SRA 0x80000000 by alu_b=0x24 -> 0xF8000000.
REQ-037 MUL 0x0001_0003*0x0000_0005 -> 0x0005_000F, out_valid exactly 32 cycles after accept, in_ready 0 in between.
REQ-038 Back-pressure: out_ready=0 for 5 cycles after ADD result -> result/flags stable, in_ready 0, next op accepted on drain edge, back-to-back stream of 10 ADDs with out_ready=1 -> one result per cycle.
REQ-039 rst_n=0 at iteration 10 of MUL -> out_valid stays 0, in_ready 1 after release; next ADD 2+3 -> 5.
REQ-040 Build without ALU_MUL_EN: op 0C on 6,7 -> alu_out 0, zero 1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the pipelined ALU.
package alu_pkg;

    localparam logic [4:0] A_NOP  = 5'h00;
    localparam logic [4:0] A_ADD  = 5'h01;
    localparam logic [4:0] A_SUB  = 5'h02;
    localparam logic [4:0] A_AND  = 5'h03;
    localparam logic [4:0] A_OR   = 5'h04;
    localparam logic [4:0] A_XOR  = 5'h05;
    localparam logic [4:0] A_NOR  = 5'h06;
    localparam logic [4:0] A_SLT  = 5'h07;
    localparam logic [4:0] A_SLTU = 5'h08;
    localparam logic [4:0] A_SLL  = 5'h09;
    localparam logic [4:0] A_SRL  = 5'h0A;
    localparam logic [4:0] A_SRA  = 5'h0B;
    localparam logic [4:0] A_MUL  = 5'h0C;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of product.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_next;

    // done/product are combinational on the final iteration so the top can
    // register the result on the same edge the last partial sum is formed.
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = busy_q && (cnt_q == LAST);
        product  = acc_next;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule
`endif

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshake on both sides and registered flags.
// Optional iterative MUL (opcode 0C) enabled by defining ALU_MUL_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [4:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_c, wr_v;

`ifdef ALU_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (alu_a),
        .b       (alu_b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        diff  = {1'b0, alu_a} - {1'b0, alu_b};
        shamt = alu_b[SHW-1:0];
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (alu_op)
            A_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
            end
            A_SUB: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
            end
            A_AND:  res = alu_a & alu_b;
            A_OR:   res = alu_a | alu_b;
            A_XOR:  res = alu_a ^ alu_b;
            A_NOR:  res = ~(alu_a | alu_b);
            A_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            A_SLTU: res = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
            A_SLL:  res = alu_a << shamt;
            A_SRL:  res = alu_a >> shamt;
            A_SRA:  res = $signed(alu_a) >>> shamt;
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        alu_out_d   = alu_out_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;
        wr_data     = res;
        wr_c        = res_c;
        wr_v        = res_v;
`ifdef ALU_MUL_EN
        mul_start   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (alu_op == A_MUL) begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
`else
                    wr_en = 1'b1;
`endif
                end
            end
            ST_MUL: begin
`ifdef ALU_MUL_EN
                if (mul_done) begin
                    wr_en   = 1'b1;
                    wr_data = mul_product;
                    wr_c    = 1'b0;
                    wr_v    = 1'b0;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
        // A new result overrides the drain so accept+drain on one edge stays valid.
        if (wr_en) begin
            out_valid_d = 1'b1;
            alu_out_d   = wr_data;
            zero_d      = (wr_data == '0);
            carry_d     = wr_c;
            overflow_d  = wr_v;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=32; MUL scenarios follow ALU_MUL_EN.
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        zero;
    logic        carry;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one operation (caller guarantees in_ready) and return #1 after its accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        alu_a    = a;
        alu_b    = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        alu_op = 5'h01; alu_a = 32'h1; alu_b = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_assert++;
        if ({out_valid, alu_out, zero, carry, overflow} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b out=%h z=%b c=%b o=%b required all 0",
                     out_valid, alu_out, zero, carry, overflow);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_add_overflow;
        issue(5'h01, 32'h7FFF_FFFF, 32'h0000_0001);
        n_assert++;
        if ({out_valid, alu_out, zero, carry, overflow} !== {1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_ovf: got v=%b out=%h z=%b c=%b o=%b required v=1 out=80000000 z=0 c=0 o=1",
                     out_valid, alu_out, zero, carry, overflow);
        end
        @(posedge clk);
        #1;
        n_assert++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_drain: out_valid got %b required 0", out_valid);
        end
    endtask

    task automatic test_ops;
        logic [4:0]  t_op [14];
        logic [31:0] t_a  [14];
        logic [31:0] t_b  [14];
        logic [31:0] t_r  [14];
        logic [1:0]  t_cv [14];
        t_op[0]  = 5'h02; t_a[0]  = 32'h0000_0005; t_b[0]  = 32'h0000_0005; t_r[0]  = 32'h0000_0000; t_cv[0]  = 2'b00;
        t_op[1]  = 5'h02; t_a[1]  = 32'h0000_0000; t_b[1]  = 32'h0000_0001; t_r[1]  = 32'hFFFF_FFFF; t_cv[1]  = 2'b10;
        t_op[2]  = 5'h02; t_a[2]  = 32'h8000_0000; t_b[2]  = 32'h0000_0001; t_r[2]  = 32'h7FFF_FFFF; t_cv[2]  = 2'b01;
        t_op[3]  = 5'h01; t_a[3]  = 32'hFFFF_FFFF; t_b[3]  = 32'h0000_0001; t_r[3]  = 32'h0000_0000; t_cv[3]  = 2'b10;
        t_op[4]  = 5'h03; t_a[4]  = 32'hF0F0_1234; t_b[4]  = 32'h0FF0_FF00; t_r[4]  = 32'h00F0_1200; t_cv[4]  = 2'b00;
        t_op[5]  = 5'h04; t_a[5]  = 32'hF0F0_1234; t_b[5]  = 32'h0FF0_FF00; t_r[5]  = 32'hFFF0_FF34; t_cv[5]  = 2'b00;
        t_op[6]  = 5'h05; t_a[6]  = 32'hF0F0_1234; t_b[6]  = 32'h0FF0_FF00; t_r[6]  = 32'hFF00_ED34; t_cv[6]  = 2'b00;
        t_op[7]  = 5'h06; t_a[7]  = 32'hF0F0_1234; t_b[7]  = 32'h0FF0_FF00; t_r[7]  = 32'h000F_00CB; t_cv[7]  = 2'b00;
        t_op[8]  = 5'h07; t_a[8]  = 32'hFFFF_FFFF; t_b[8]  = 32'h0000_0001; t_r[8]  = 32'h0000_0001; t_cv[8]  = 2'b00;
        t_op[9]  = 5'h08; t_a[9]  = 32'hFFFF_FFFF; t_b[9]  = 32'h0000_0001; t_r[9]  = 32'h0000_0000; t_cv[9]  = 2'b00;
        t_op[10] = 5'h09; t_a[10] = 32'h0000_0001; t_b[10] = 32'h0000_0021; t_r[10] = 32'h0000_0002; t_cv[10] = 2'b00;
        t_op[11] = 5'h0A; t_a[11] = 32'h8000_0000; t_b[11] = 32'h0000_001F; t_r[11] = 32'h0000_0001; t_cv[11] = 2'b00;
        t_op[12] = 5'h0B; t_a[12] = 32'h8000_0000; t_b[12] = 32'h0000_0024; t_r[12] = 32'hF800_0000; t_cv[12] = 2'b00;
        t_op[13] = 5'h1F; t_a[13] = 32'h1234_5678; t_b[13] = 32'h1111_1111; t_r[13] = 32'h0000_0000; t_cv[13] = 2'b00;
        for (int i = 0; i < 14; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            n_assert++;
            if ({out_valid, alu_out, zero, carry, overflow} !==
                {1'b1, t_r[i], (t_r[i] == 32'h0), t_cv[i]}) begin
                n_fail++;
                $display("FAIL op_vec%0d op=%h: got v=%b out=%h z=%b c=%b o=%b required v=1 out=%h z=%b c=%b o=%b",
                         i, t_op[i], out_valid, alu_out, zero, carry, overflow,
                         t_r[i], (t_r[i] == 32'h0), t_cv[i][1], t_cv[i][0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        issue(5'h01, 32'd10, 32'd20);
        in_valid = 1'b1;
        alu_op = 5'h01; alu_a = 32'd1; alu_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            n_assert++;
            if ({out_valid, alu_out, zero, carry, overflow, in_ready} !== {1'b1, 32'd30, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b out=%h z=%b c=%b o=%b rdy=%b required v=1 out=1e flags 0 rdy=0",
                         i, out_valid, alu_out, zero, carry, overflow, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_on_drain: got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_assert++;
        if ({out_valid, alu_out} !== {1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL bp_accept_on_drain: got v=%b out=%h required v=1 out=2", out_valid, alu_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            alu_op = 5'h01;
            alu_a = i;
            alu_b = 32'd1000;
            n_assert++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got %b required 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            n_assert++;
            if ({out_valid, alu_out} !== {1'b1, 32'd1000 + 32'(i)}) begin
                n_fail++;
                $display("FAIL b2b_result%0d: got v=%b out=%h required v=1 out=%h",
                         i, out_valid, alu_out, 32'd1000 + 32'(i));
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_held_result;
        out_ready = 1'b0;
        issue(5'h01, 32'hFFFF_FFFF, 32'h0000_0001);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_assert++;
        if ({out_valid, alu_out, zero, carry, overflow} !== 36'h0) begin
            n_fail++;
            $display("FAIL rst_held: got v=%b out=%h z=%b c=%b o=%b required all 0",
                     out_valid, alu_out, zero, carry, overflow);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_held_ready: got %b required 1", in_ready);
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul;
        int early;
        logic [31:0] m_a [2];
        logic [31:0] m_b [2];
        logic [31:0] m_r [2];
        m_a[0] = 32'h0001_0003; m_b[0] = 32'h0000_0005; m_r[0] = 32'h0005_000F;
        m_a[1] = 32'h1234_5678; m_b[1] = 32'h0000_0010; m_r[1] = 32'h2345_6780;
        for (int k = 0; k < 2; k++) begin
            early = 0;
            issue(5'h0C, m_a[k], m_b[k]);
            for (int j = 1; j < 32; j++) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b0) early++;
                @(posedge clk);
                #1;
            end
            if (out_valid !== 1'b0 || in_ready !== 1'b0) early++;
            n_assert++;
            if (early != 0) begin
                n_fail++;
                $display("FAIL mul_busy%0d: %0d cycles with out_valid or in_ready set, required 0", k, early);
            end
            @(posedge clk);
            #1;
            n_assert++;
            if ({out_valid, alu_out, zero, carry, overflow} !== {1'b1, m_r[k], 3'b000}) begin
                n_fail++;
                $display("FAIL mul_result%0d: got v=%b out=%h z=%b c=%b o=%b required v=1 out=%h flags 0",
                         k, out_valid, alu_out, zero, carry, overflow, m_r[k]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mul_reset;
        int seen;
        seen = 0;
        issue(5'h0C, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mulrst_ready: got %b required 1", in_ready);
        end
        for (int j = 0; j < 40; j++) begin
            if (out_valid !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        n_assert++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mulrst_no_result: out_valid seen %0d cycles required 0", seen);
        end
        issue(5'h01, 32'd2, 32'd3);
        n_assert++;
        if ({out_valid, alu_out} !== {1'b1, 32'd5}) begin
            n_fail++;
            $display("FAIL mulrst_add: got v=%b out=%h required v=1 out=5", out_valid, alu_out);
        end
        @(posedge clk);
        #1;
    endtask
`else
    task automatic test_mul_disabled;
        issue(5'h0C, 32'd6, 32'd7);
        n_assert++;
        if ({out_valid, alu_out, zero, carry, overflow, in_ready} !== {1'b1, 32'h0, 1'b1, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL nomul_0c: got v=%b out=%h z=%b c=%b o=%b rdy=%b required v=1 out=0 z=1 c=0 o=0 rdy=1",
                     out_valid, alu_out, zero, carry, overflow, in_ready);
        end
        issue(5'h01, 32'd2, 32'd3);
        n_assert++;
        if ({out_valid, alu_out} !== {1'b1, 32'd5}) begin
            n_fail++;
            $display("FAIL nomul_next_add: got v=%b out=%h required v=1 out=5", out_valid, alu_out);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 5'h00;
        alu_a     = 32'h0;
        alu_b     = 32'h0;
        test_reset();
        test_add_overflow();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_held_result();
`ifdef ALU_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
